// File: rtl/mux_scan_sel_pkg.sv
// Purpose: shared mode encodings, select-width helper and channel packing for mux_scan_sel.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block family).
//
// Packing: channel i of a flat data bus lives in bits [chan_lsb(i, WIDTH) +: WIDTH].
package mux_scan_sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A select field is never narrower than one bit, even for a 2-way selector.
    function automatic int sel_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int chan_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mux_scan_sel_if.sv
// Purpose: control/data bundle between the sources (master) and the selector (slave).
// Latency: n/a (wires only).
// Backpressure: none; outputs are sampled every cycle by the sink.
//
// master drives mode, sel_in, en_mask, hold, data_in and observes the outputs;
// slave (the selector) drives data_out, sel_out, valid_out and wrap.
interface mux_scan_sel_if
    import mux_scan_sel_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 2,
    parameter int SEL_W = sel_w_f(N)
);
    logic                 mode;
    logic [SEL_W-1:0]     sel_in;
    logic [N-1:0]         en_mask;
    logic                 hold;
    logic [N*WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]     data_out;
    logic [SEL_W-1:0]     sel_out;
    logic                 valid_out;
    logic                 wrap;

    modport master (
        output mode, sel_in, en_mask, hold, data_in,
        input  data_out, sel_out, valid_out, wrap
    );

    modport slave (
        input  mode, sel_in, en_mask, hold, data_in,
        output data_out, sel_out, valid_out, wrap
    );
endinterface

// File: rtl/mux_scan_sel_next_en_idx.sv
// Purpose: find the next enabled channel strictly after cur, wrapping to the lowest enabled one.
// Latency: combinational.
// Backpressure: none.
//
// Ports: en_mask/cur in; nxt (next index), wrapped (nxt <= cur), any_en (mask non-zero) out.
// An out-of-range cur has no enabled channel above it, so it always wraps.
module mux_scan_sel_next_en_idx #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     en_mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             wrapped,
    output logic             any_en
);
    logic             found_hi;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;

    // Walk downwards so the last hit in each category is the lowest index.
    always_comb begin
        found_hi = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) > cur) begin
                    found_hi = 1'b1;
                    hi_idx   = SEL_W'(i);
                end
            end
        end
    end

    assign any_en  = |en_mask;
    assign nxt     = found_hi ? hi_idx : lo_idx;
    assign wrapped = any_en & ~found_hi;

endmodule

// File: rtl/mux_scan_sel.sv
// Purpose: N-way WIDTH-bit channel selector, manual (sel_in) or auto-scan over enabled channels.
// Latency: one cycle from sel_in/data_in/en_mask to data_out/valid_out.
// Backpressure: none; hold freezes selection and dwell count but data keeps tracking.
//
// Ports: clock, reset_n (async, active low), bus (slave modport of mux_scan_sel_if).
// sel_out always names the channel whose data is in data_out this cycle.
module mux_scan_sel
    import mux_scan_sel_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 2,
    parameter int DWELL = 3,
    parameter int SEL_W = sel_w_f(N)
) (
    input  logic         clock,
    input  logic         reset_n,
    mux_scan_sel_if.slave bus
);
    localparam int MP_W = 1 << SEL_W;
    localparam int DW_W = (DWELL <= 1) ? 1 : $clog2(DWELL);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] scan_idx;
    logic [DW_W-1:0]  dwell_cnt;
    logic [DW_W-1:0]  dwell_next;
    logic             wrap_next;
    logic             scan_wrapped;
    logic             any_en;
    logic             cur_ok;
    logic             sel_ok;
    logic [MP_W-1:0]  mask_pad;
    logic [WIDTH-1:0] sel_dat;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             wrap_q;

    // Zero-extend the mask to every encodable index so out-of-range
    // selections simply read as disabled.
    assign mask_pad = MP_W'(bus.en_mask);
    assign cur_ok   = mask_pad[sel_q];
    assign sel_ok   = mask_pad[sel_next];

    mux_scan_sel_next_en_idx #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_next_en_idx (
        .en_mask (bus.en_mask),
        .cur     (sel_q),
        .nxt     (scan_idx),
        .wrapped (scan_wrapped),
        .any_en  (any_en)
    );

    always_comb begin
        sel_next   = sel_q;
        dwell_next = dwell_cnt;
        wrap_next  = 1'b0;
        if (!bus.hold) begin
            case (bus.mode)
                MODE_MANUAL: begin
                    sel_next   = bus.sel_in;
                    dwell_next = '0;
                end
                MODE_SCAN: begin
                    if (!any_en) begin
                        dwell_next = '0;
                    end else if (!cur_ok || dwell_cnt == DWELL_LAST) begin
                        // A disabled/out-of-range current channel is skipped
                        // immediately, without waiting out the dwell.
                        sel_next   = scan_idx;
                        dwell_next = '0;
                        wrap_next  = scan_wrapped;
                    end else begin
                        dwell_next = dwell_cnt + DW_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_next == SEL_W'(i)) begin
                sel_dat = bus.data_in[chan_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= '0;
            dwell_cnt <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            sel_q     <= sel_next;
            dwell_cnt <= dwell_next;
            data_q    <= sel_ok ? sel_dat : '0;
            valid_q   <= sel_ok;
            wrap_q    <= wrap_next;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.sel_out   = sel_q;
    assign bus.valid_out = valid_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised N-way, WIDTH-bit channel selector with a registered output; the successor of the fixed 4-to-1, 2-bit combinational selector.
- Two modes:
  - Manual: the channel comes from the select input.
  - Auto-scan: the block steps through the enabled channels, dwelling DWELL cycles on each.
- Sits between board switch/data sources and display/LED sinks.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 2, bits per channel.
- DWELL, 3, cycles spent on each channel in scan mode (>= 1).
- SEL_W, clog2(N), select width (derived, minimum 1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel_in  in  SEL_W  channel index, used in manual mode.
- en_mask  in  N  per-channel enable; bit i enables channel i.
- hold  in  1  freezes the selection and the dwell counter.
- data_in  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- data_out  out  WIDTH  registered selected data.
- sel_out  out  SEL_W  currently selected index (sel_q).
- valid_out  out  1  data_out is from a legal, enabled channel.
- wrap  out  1  one-cycle pulse when the scan wraps around.

Behaviour:
- Reset (reset_n low, asynchronous): data_out=0, sel_out=0, valid_out=0, wrap=0, dwell_cnt=0.
  - Release is sampled on clock.
  - Asserting reset mid-scan aborts immediately; the scan restarts at index 0.
- Output path:
  - Each cycle: data_out <= sel_ok ? data_in[sel_next] : 0; valid_out <= sel_ok.
  - sel_next is the selection being loaded this cycle.
  - sel_ok = (sel_next < N) && en_mask[sel_next].
  - Latency is one cycle from a sel_in/data_in change to data_out.
  - data_out keeps tracking data_in of the held channel even while hold=1.
- Manual mode (mode=0):
  - sel_next = sel_in.
  - Out-of-range sel_in (>= N, possible when N is not a power of 2): data_out=0, valid_out=0. This preserves the legacy default-zero behaviour.
  - dwell_cnt is held at 0; wrap=0.
- Scan mode (mode=1):
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt == DWELL-1: dwell_cnt -> 0 and sel_q -> next enabled index strictly greater than sel_q, wrapping circularly to the lowest enabled index.
  - wrap pulses in the cycle sel_q is updated, whenever the new index <= the old index.
  - Only one channel enabled: the block re-selects that channel every DWELL cycles and wrap pulses each time.
  - en_mask == 0: sel_q holds, dwell_cnt=0, valid_out=0, data_out=0, wrap=0.
  - Current sel_q disabled, or out of range, while the mask is non-zero: the block advances to the next enabled channel on the next edge regardless of dwell_cnt, and dwell_cnt resets to 0.
  - DWELL=1: the block advances every cycle.
- Mode changes:
  - Manual -> scan: scanning starts from the current sel_q with dwell_cnt=0.
  - Scan -> manual: sel_in takes effect on the first manual-mode edge.
- Hold:
  - sel_q and dwell_cnt are frozen in both modes; wrap=0.
  - Hold has priority over advancing and over the forced skip of a disabled channel.
  - valid_out still re-evaluates en_mask each cycle.

Decomposition:
- Shared package:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - A clog2-based SEL_W helper.
  - The data_in slice/packing convention.
- One sub-module, next_en_idx (purely combinational):
  - Inputs: en_mask, cur index.
  - Outputs: next enabled index (circular, strictly after cur), wrapped flag, any_en.
  - Instantiated once and tested standalone.
- The top level holds sel_q, dwell_cnt and the output registers.

Test Plan (N=4, WIDTH=2, DWELL=3, data_in channel i = i, i.e. ch0=0, ch1=1, ch2=2, ch3=3):
- Manual sweep: mode=0, en_mask=4'b1111, sel_in=0,1,2,3 on consecutive cycles -> data_out=0,1,2,3 one cycle later, valid_out=1, wrap=0.
- Scan with full mask: mode=1 from reset -> sel_out dwells 3 cycles on each of 0,1,2,3,0; wrap=1 for exactly one cycle on the 3->0 transition, i.e. every 12 cycles.
- Scan with sparse mask: en_mask=4'b1010 -> sel_out sequence 1,3,1,3, each held 3 cycles; wrap pulses on 3->1. Then clear en_mask bit 3 while on 3 -> next cycle sel_out=1 and dwell_cnt=0.
- Empty mask and hold: en_mask=0 in scan mode -> valid_out=0, data_out=0, sel_out frozen. With full mask and hold=1 for 5 cycles mid-dwell -> sel_out unchanged and the dwell resumes its remaining count after release.
- Async reset mid-scan: assert reset_n=0 between clock edges while sel_out=2 -> all outputs 0 immediately. Release -> scan restarts at 0 with the full 3-cycle dwell.
- N=3 build, manual mode, sel_in=3 -> data_out=0, valid_out=0.
